// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or unsigned.
// Request and result each use a valid/ready handshake; results are held until taken.
module seq_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready depends only on state; out_valid and the result stay stable until out_ready.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q_sh;     // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs_mag;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)                state_nxt = S_PREP;
      S_PREP: state_nxt = (dvs_mag == '0) ? S_DONE : S_ITER;
      S_ITER: if (cnt == CNT_W'(1))        state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: if (out_valid && out_ready)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE);
  end

  // A set top bit of the shifted remainder guarantees the subtraction succeeds and
  // that the true difference fits in WIDTH bits, so a WIDTH-bit subtract suffices.
  always_comb begin
    shifted = {rem, q_sh[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - dvs_mag;
    ge      = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs_mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sh        <= '0;
      rem         <= '0;
      dvs_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            q_sh    <= dividend;
            dvs_mag <= divisor;
            neg_q   <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= is_signed && dividend[WIDTH-1];
          end
        end
        S_PREP: begin
          if (dvs_mag == '0) begin
            quotient    <= '1;
            remainder   <= q_sh;
            div_by_zero <= 1'b1;
          end else begin
            // neg_q ^ neg_r recovers the divisor sign without storing is_signed.
            q_sh    <= neg_r ? -q_sh : q_sh;
            dvs_mag <= (neg_q ^ neg_r) ? -dvs_mag : dvs_mag;
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH);
          end
        end
        S_ITER: begin
          q_sh <= {q_sh[WIDTH-2:0], ge};
          rem  <= ge ? diff : shifted[WIDTH-1:0];
          cnt  <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          quotient    <= neg_q ? -q_sh : q_sh;
          remainder   <= neg_r ? -rem : rem;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
      out_valid <= (state == S_DONE) && !(out_valid && out_ready);
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases plus random operands checked
// against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: divide magnitudes with native unsigned arithmetic, then apply signs.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    logic na, nb;
    logic [W-1:0] ma, mb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
      return;
    end
    na = s && a[W-1];
    nb = s && b[W-1];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    z = 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
    logic [W-1:0] eq, er;
    logic ez;
    int cyc, lat;
    bit busy_ok, stable_ok;
    ref_div(a, b, s, eq, er, ez);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    lat = (b == '0) ? 2 : W + 3;

    @(negedge clk);
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dividend  = rand_word();
    divisor   = rand_word();
    is_signed = 1'($urandom_range(0, 1));

    cyc = 0;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", W'(cyc), W'(lat));
    check("in_ready_busy", W'(busy_ok), W'(1));
    check("quotient", quotient, exp_q.pop_front());
    check("remainder", remainder, exp_q.pop_front());
    check("div_by_zero", W'(div_by_zero), W'(ez));

    if (hold > 0) begin
      stable_ok = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        dividend = rand_word();
        divisor  = rand_word();
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq ||
            remainder !== er || div_by_zero !== ez) stable_ok = 1'b0;
      end
      in_valid = 1'b0;
      check("hold_stable", W'(stable_ok), W'(1));
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", W'(out_valid), W'(0));
    check("in_ready_back", W'(in_ready), W'(1));
    check("quotient_retained", quotient, eq);
  endtask

  initial begin
    logic [W-1:0] min_neg, a, b;
    min_neg = {1'b1, {(W-1){1'b0}}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_div_by_zero", W'(div_by_zero), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_div(W'(100), W'(7), 1'b0, 0);
    check("u100_7_q_const", quotient, W'(14));
    run_div(-(W'(100)), W'(7), 1'b1, 0);
    check("s-100_7_q_const", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
    run_div(W'(100), -(W'(7)), 1'b1, 0);
    run_div(W'(16'h1234), W'(0), 1'b0, 0);
    run_div(min_neg, '1, 1'b1, 0);
    check("ovf_q_const", quotient, min_neg);
    run_div('1, W'(1), 1'b0, 0);
    run_div(W'(0), W'(5), 1'b1, 0);
    run_div(W'(77), W'(0), 1'b1, 0);

    // Result held with out_ready low while a new request is offered.
    run_div(W'(1000), W'(33), 1'b0, 10);
    run_div(W'(50), W'(5), 1'b0, 0);

    // Reset in the middle of the iterations.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = W'(12345);
    divisor  = W'(7);
    is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (31) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(1));
    check("midrst_quotient", quotient, '0);
    check("midrst_remainder", remainder, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div(W'(9), W'(3), 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      a = rand_word();
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        default: b = rand_word() >> $urandom_range(0, W - 1);
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, W - 1);
      run_div(a, b, 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring integer divider; the inverse operation of the team's carry-save multiplier datapath.
- Accepts one dividend/divisor pair through a valid/ready handshake and resolves one quotient bit per cycle.
- Returns quotient and remainder on a held output handshake.
- Sits beside the multiplier in the execute stage for DIV/DIVU/REM/REMU.

Parameters:
- WIDTH, 64, operand/result bit width (even, >= 4)
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
- clk, input, 1, single clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, request valid
- in_ready, output, 1, divider can accept a request
- is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned
- dividend, input, WIDTH, numerator
- divisor, input, WIDTH, denominator
- out_valid, output, 1, result valid
- out_ready, input, 1, consumer takes result
- quotient, output, WIDTH, result quotient
- remainder, output, WIDTH, result remainder
- div_by_zero, output, 1, flag, valid with out_valid

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; counter=0.
- Accept when in_valid && in_ready (cycle 0). Latch operands, is_signed, neg_q = signed && (sign(dvd) ^ sign(dvs)), neg_r = signed && sign(dvd).
- in_ready=1 only in IDLE. Inputs are ignored in all other states.
- States and transitions:
  - IDLE -> PREP on accept.
  - PREP (1 cycle): if divisor==0 -> DONE directly, with quotient = all ones, remainder = original dividend, div_by_zero=1. Otherwise take magnitudes (abs when signed), partial remainder = 0, counter = WIDTH -> ITER.
  - ITER (exactly WIDTH cycles): shift {rem, dvd} left 1; trial = rem - divisor_mag on WIDTH+1 bits; if trial >= 0 then rem = trial and quotient bit = 1, else quotient bit = 0. Decrement counter; at 1 -> FIX.
  - FIX (1 cycle): quotient = neg_q ? -q : q; remainder = neg_r ? -r : r (mod 2^WIDTH) -> DONE.
  - DONE: out_valid=1. Hold all outputs stable until out_ready. On out_valid && out_ready -> IDLE, out_valid=0 next cycle.
- Latency:
  - Normal operation: out_valid rises WIDTH+3 cycles after the accept edge (PREP + WIDTH×ITER + FIX + DONE register).
  - Divide-by-zero: out_valid rises 2 cycles after accept.
- Back-to-back: in_ready returns 1 the cycle after the output handshake. No accept in the same cycle as the output handshake.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0. Falls out of the magnitude datapath (|MIN| = 2^(WIDTH-1) unsigned, negation wraps). No special case and no flag.
- Quotient truncates toward zero. Sign of a nonzero remainder equals the sign of the dividend.
- Dividend of 0 still takes the full WIDTH iterations: quotient=0, remainder=0.
- quotient/remainder/div_by_zero change only on entry to DONE. They retain the last result while IDLE.
- Async reset mid-operation aborts immediately to the reset values. No partial result is ever presented.
- out_ready held low: DONE persists indefinitely, in_ready stays 0.

Test Plan:
- Reset then unsigned 100/7 (WIDTH=64) -> quotient=14, remainder=2, div_by_zero=0; out_valid exactly 67 cycles after accept; in_ready=0 throughout.
- Signed -100/7 -> quotient=-14 (0xFFFF_FFFF_FFFF_FFF2), remainder=-2; signed 100/-7 -> quotient=-14, remainder=2.
- Divide by zero, unsigned 0x1234/0 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1; out_valid 2 cycles after accept.
- Signed 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0; unsigned 0xFFFF_FFFF_FFFF_FFFF/1 -> quotient=all ones, remainder=0.
- Hold out_ready=0 for 10 cycles after out_valid while driving in_valid=1 -> outputs stable, no new accept. Release out_ready -> in_ready=1 next cycle; second request 50/5 returns quotient=10, remainder=0.
- Deassert rst_n at iteration 30 of a division -> out_valid=0 and in_ready=1 asynchronously, state IDLE. Next request 9/3 -> quotient=3, remainder=0.
